mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset datapath (add, sub, sll/nop, ori, lw, sw, beq, lui, jal, jr). It sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB. It asserts per-state write enables for the PC, IR, GRF and DM, and holds in MEM until data memory acknowledges. It replaces single-cycle decode wherever the datapath shares one memory port or needs a wait-stated memory.

---
 rtl/mc_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional retired-instruction counter enabled by defining MC_CTRL_RETIRE_CNT_EN.
module mc_ctrl #(
  parameter int MC_CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic [2:0]  npc_op,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        sll_sign,
  output logic        reg_dst,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        link,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  state,
  output logic        illegal
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [MC_CNT_W-1:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_SLL, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_JR, K_ILL
  } kind_e;

  state_e state_q, state_d;
  kind_e  kind;
  logic   in_body;

  // Only opcode and funct matter to control; register/immediate fields belong to the datapath.
  logic unused_instr_fields;
  assign unused_instr_fields = ^instr[25:6];

  always_comb begin
    kind = K_ILL;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20:   kind = K_ADD;
          6'h22:   kind = K_SUB;
          6'h00:   kind = K_SLL;
          6'h08:   kind = K_JR;
          default: kind = K_ILL;
        endcase
      end
      6'h0D:   kind = K_ORI;
      6'h23:   kind = K_LW;
      6'h2B:   kind = K_SW;
      6'h04:   kind = K_BEQ;
      6'h0F:   kind = K_LUI;
      6'h03:   kind = K_JAL;
      default: kind = K_ILL;
    endcase
  end

  assign in_body = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  // NOTE: every output and state_d gets a default before any branch, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    npc_op     = 3'b000;
    alu_op     = 3'b101;
    alu_src    = 1'b0;
    sll_sign   = 1'b0;
    reg_dst    = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    illegal    = 1'b0;
    state_d    = S_FETCH;

    // Datapath steering stays stable from EXEC through WB of the same instruction.
    if (in_body) begin
      case (kind)
        K_SLL:             alu_op = 3'b000;
        K_SUB:             alu_op = 3'b001;
        K_ORI:             alu_op = 3'b010;
        K_ADD, K_LW, K_SW: alu_op = 3'b011;
        K_LUI:             alu_op = 3'b100;
        default:           alu_op = 3'b101;
      endcase
      alu_src    = (kind == K_ORI) || (kind == K_LW) || (kind == K_SW) || (kind == K_LUI);
      sll_sign   = (kind == K_SLL);
      reg_dst    = (kind == K_ADD) || (kind == K_SUB) || (kind == K_SLL);
      mem_to_reg = (kind == K_LW);
      link       = (kind == K_JAL);
    end

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (kind == K_ILL) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (kind)
          K_BEQ: begin
            npc_op  = 3'b001;
            pc_we   = zero;
            state_d = S_FETCH;
          end
          K_JR: begin
            npc_op  = 3'b100;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
          K_JAL: begin
            npc_op  = 3'b010;
            pc_we   = 1'b1;
            state_d = S_WB;
          end
          K_LW, K_SW: state_d = S_MEM;
          K_ILL:      state_d = S_FETCH;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (kind == K_SW);
        if (mem_ready) state_d = (kind == K_SW) ? S_FETCH : S_WB;
        else           state_d = S_MEM;
      end
      S_WB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Side-effecting enables are killed combinationally so reset abandons any access at once.
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      illegal = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [MC_CNT_W-1:0] retire_q, retire_d;
  logic                retire_evt;

  assign retire_evt = in_body && (state_d == S_FETCH);
  assign retire_d   = retire_evt ? retire_q + MC_CNT_W'(1) : retire_q;

  always_ff @(posedge clk) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction streams
// checked against a per-instruction state-sequence model.
module tb_mc_ctrl;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_we, ir_we, alu_src, sll_sign, reg_dst, reg_we;
  logic        mem_to_reg, link, mem_req, mem_we, illegal;
  logic [2:0]  npc_op, alu_op, state;

  int checks = 0;
  int errors = 0;

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [CW-1:0] retire_cnt;
  logic [CW-1:0] exp_cnt = '0;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.MC_CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .npc_op(npc_op), .alu_op(alu_op), .alu_src(alu_src),
    .sll_sign(sll_sign), .reg_dst(reg_dst), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .link(link), .mem_req(mem_req), .mem_we(mem_we), .state(state), .illegal(illegal)
`ifdef MC_CTRL_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  typedef enum int {K_ADD, K_SUB, K_SLL, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_JR, K_ILL} kind_e;

  logic [5:0] ill_ops [8] = '{6'h3F, 6'h02, 6'h08, 6'h05, 6'h09, 6'h0C, 6'h20, 6'h28};
  logic [5:0] ill_fns [8] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h02, 6'h03, 6'h27};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(kind_e k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADD:   return {6'h00, r[25:6], 6'h20};
      K_SUB:   return {6'h00, r[25:6], 6'h22};
      K_SLL:   return {6'h00, r[25:6], 6'h00};
      K_JR:    return {6'h00, r[25:6], 6'h08};
      K_ORI:   return {6'h0D, r[25:0]};
      K_LW:    return {6'h23, r[25:0]};
      K_SW:    return {6'h2B, r[25:0]};
      K_BEQ:   return {6'h04, r[25:0]};
      K_LUI:   return {6'h0F, r[25:0]};
      K_JAL:   return {6'h03, r[25:0]};
      default: return r[31] ? {ill_ops[r[30:28]], r[25:0]} : {6'h00, r[25:6], ill_fns[r[30:28]]};
    endcase
  endfunction

  function automatic logic writes_reg(kind_e k);
    return k inside {K_ADD, K_SUB, K_SLL, K_ORI, K_LUI, K_JAL, K_LW};
  endfunction

  function automatic logic [2:0] exp_alu(kind_e k);
    case (k)
      K_SLL:             return 3'b000;
      K_SUB:             return 3'b001;
      K_ORI:             return 3'b010;
      K_ADD, K_LW, K_SW: return 3'b011;
      K_LUI:             return 3'b100;
      default:           return 3'b101;
    endcase
  endfunction

  // Entered one time unit after a rising edge in FETCH; leaves in the same phase at the next FETCH.
  task automatic run_instr(input logic [31:0] ins, input kind_e k, input logic z, input int nw);
    int seq[$];
    int mem_seen;
    int s;
    logic       e_pc, e_ir, e_rw, e_mr, e_mw, e_il;
    logic [2:0] e_npc;
    seq = '{0, 1};
    if (k != K_ILL) seq.push_back(2);
    if (k == K_LW || k == K_SW) repeat (nw + 1) seq.push_back(3);
    if (writes_reg(k)) seq.push_back(4);
    mem_seen = 0;
    instr = ins;
    foreach (seq[i]) begin
      s = seq[i];
      zero = (k == K_BEQ && s == 2) ? z : 1'($urandom);
      if (s == 3) begin
        mem_ready = (mem_seen == nw);
        mem_seen++;
      end else begin
        mem_ready = 1'($urandom);
      end
      e_pc = 0; e_ir = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_il = 0; e_npc = 3'b000;
      case (s)
        0: begin e_pc = 1; e_ir = 1; end
        1: e_il = (k == K_ILL);
        2: begin
          if (k == K_BEQ) begin e_npc = 3'b001; e_pc = z; end
          if (k == K_JR)  begin e_npc = 3'b100; e_pc = 1; end
          if (k == K_JAL) begin e_npc = 3'b010; e_pc = 1; end
        end
        3: begin e_mr = 1; e_mw = (k == K_SW); end
        default: e_rw = 1;
      endcase
      @(negedge clk);
      check($sformatf("state@%0d", i), state, s);
      check($sformatf("pc_we s%0d", s), pc_we, e_pc);
      check($sformatf("ir_we s%0d", s), ir_we, e_ir);
      check($sformatf("npc_op s%0d", s), npc_op, e_npc);
      check($sformatf("reg_we s%0d", s), reg_we, e_rw);
      check($sformatf("mem_req s%0d", s), mem_req, e_mr);
      check($sformatf("mem_we s%0d", s), mem_we, e_mw);
      check($sformatf("illegal s%0d", s), illegal, e_il);
      if (s >= 2) begin
        check($sformatf("alu_op s%0d", s), alu_op, exp_alu(k));
        check($sformatf("alu_src s%0d", s), alu_src, k inside {K_ORI, K_LW, K_SW, K_LUI});
        check($sformatf("sll_sign s%0d", s), sll_sign, k == K_SLL);
        check($sformatf("reg_dst s%0d", s), reg_dst, k inside {K_ADD, K_SUB, K_SLL});
        check($sformatf("mem_to_reg s%0d", s), mem_to_reg, k == K_LW);
        check($sformatf("link s%0d", s), link, k == K_JAL);
      end
      @(posedge clk);
      #1;
    end
    check("back_to_fetch", state, 0);
`ifdef MC_CTRL_RETIRE_CNT_EN
    if (k != K_ILL) exp_cnt = exp_cnt + 1'b1;
    check("retire_cnt", retire_cnt, exp_cnt);
`endif
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("rst pc_we", pc_we, 0);
      check("rst ir_we", ir_we, 0);
      check("rst reg_we", reg_we, 0);
      check("rst mem_req", mem_req, 0);
      check("rst mem_we", mem_we, 0);
      check("rst illegal", illegal, 0);
      @(posedge clk);
      #1;
    end
    check("rst state", state, 0);
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp_cnt = '0;
    check("rst retire_cnt", retire_cnt, 0);
`endif
    reset = 1'b0;
  endtask

  initial begin
    kind_e k;
    reset = 1'b1;
    instr = $urandom;
    zero = 1'b0;
    mem_ready = 1'b0;

    do_reset(2);
    run_instr(32'h0085_1020, K_ADD, 1'b0, 0);
    run_instr(32'h1085_0003, K_BEQ, 1'b1, 0);
    run_instr(32'h1085_0003, K_BEQ, 1'b0, 0);
    run_instr(32'h8C85_0004, K_LW, 1'b0, 2);
    run_instr(32'h0C00_0010, K_JAL, 1'b0, 0);
    run_instr(32'hFC00_0000, K_ILL, 1'b0, 0);
    run_instr(encode(K_SW), K_SW, 1'b0, 0);
    run_instr(encode(K_SW), K_SW, 1'b0, 3);
    run_instr(encode(K_LW), K_LW, 1'b0, 0);
    run_instr(encode(K_JR), K_JR, 1'b0, 0);
    run_instr(encode(K_SLL), K_SLL, 1'b0, 0);
    run_instr(encode(K_LUI), K_LUI, 1'b0, 0);

    // Reset during a sw MEM wait: access drops immediately, no GRF write follows.
    instr = encode(K_SW);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sw_pre state", state, i);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("sw_wait mem_req", mem_req, 1);
    check("sw_wait mem_we", mem_we, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("sw_rst state", state, 3);
    check("sw_rst mem_req", mem_req, 0);
    check("sw_rst mem_we", mem_we, 0);
    check("sw_rst reg_we", reg_we, 0);
    @(posedge clk);
    #1;
    check("sw_rst next state", state, 0);
    check("sw_rst next reg_we", reg_we, 0);
    reset = 1'b0;
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp_cnt = '0;
    check("sw_rst retire_cnt", retire_cnt, 0);
`endif

    // Sixteen adds from a cleared counter: reaches all-ones at 15, then wraps.
    do_reset(1);
    for (int i = 0; i < 16; i++) run_instr(encode(K_ADD), K_ADD, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      k = kind_e'($urandom_range(0, 10));
      run_instr(encode(k), k, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
